// File: rtl/conv_tile_if.sv
// Handshake and control bundle between the convolution tile sequencer and
// its surroundings: start/config, the three memory read/write ports and the
// PE array enable/clear controls. The sequencer owns the master modport.
interface conv_tile_if #(
  parameter int FMAP_H = 64,
  parameter int K      = 4
);
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int HW = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;

  logic          start_conv;
  logic [8:0]    cfg_ci;
  logic [1:0]    cfg_co;
  logic          busy;
  logic          end_conv;
  logic          rd_w_req;
  logic          rd_w_ack;
  logic [KW-1:0] w_row_idx;
  logic          rd_i_req;
  logic          rd_i_ack;
  logic [HW-1:0] i_row_idx;
  logic          pe_clr;
  logic          pe_en;
  logic          wr_o_req;
  logic          wr_o_ack;
  logic [HW-1:0] o_row_idx;
  logic [1:0]    co_idx;

  modport master (
    input  start_conv, cfg_ci, cfg_co, rd_w_ack, rd_i_ack, wr_o_ack,
    output busy, end_conv, rd_w_req, w_row_idx, rd_i_req, i_row_idx,
           pe_clr, pe_en, wr_o_req, o_row_idx, co_idx
  );

  modport slave (
    output start_conv, cfg_ci, cfg_co, rd_w_ack, rd_i_ack, wr_o_ack,
    input  busy, end_conv, rd_w_req, w_row_idx, rd_i_req, i_row_idx,
           pe_clr, pe_en, wr_o_req, o_row_idx, co_idx
  );
endinterface

// File: rtl/conv_tile_sequencer.sv
// Layer sequencer for the convolution PE array. For each kernel group it
// loads K kernel rows, then for every output row loads the feature rows,
// clears and runs the PE accumulators, and writes the result row back.
// Optional feature: define ROW_REUSE_EN so that output rows after the first
// of a group fetch only the newest feature row (the array shifts the rest).
// All outputs are decoded from registered state, so an async reset drops
// every request in the same cycle.
module conv_tile_sequencer #(
  parameter int FMAP_H = 64,
  parameter int K      = 4,
  parameter int CI_MAX = 256,
  parameter int CI_DEF = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  conv_tile_if.master bus
);
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int HW  = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
  localparam int CIW = 9;

  localparam logic [KW-1:0]  K_LAST   = KW'(K - 1);
  localparam logic [HW-1:0]  R_LAST   = HW'(FMAP_H - K);
  localparam logic [CIW-1:0] CI_MAX_C = CIW'(CI_MAX);
  localparam logic [CIW-1:0] CI_DEF_C = CIW'(CI_DEF);

`ifdef ROW_REUSE_EN
  localparam logic [KW-1:0]  J_FIRST_NEXT = K_LAST;  // only the newest row
`else
  localparam logic [KW-1:0]  J_FIRST_NEXT = '0;      // full K-row reload
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_I  = 3'd2;
  localparam logic [2:0] S_CLR     = 3'd3;
  localparam logic [2:0] S_COMPUTE = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]     state_q, state_d;
  logic [KW-1:0]  k_q, k_d;      // kernel row within LOAD_W
  logic [KW-1:0]  j_q, j_d;      // feature row offset within LOAD_I
  logic [HW-1:0]  r_q, r_d;      // current output row
  logic [1:0]     g_q, g_d;      // current kernel group
  logic [1:0]     gm1_q, gm1_d;  // latched groups minus one
  logic [CIW-1:0] ci_q, ci_d;    // latched effective accumulate length
  logic [CIW-1:0] cnt_q, cnt_d;  // accumulate cycle counter
  logic [CIW-1:0] ci_eff;

  // Clamp the requested channel count into the supported accumulate range.
  always_comb begin
    if (bus.cfg_ci == '0)          ci_eff = CI_DEF_C;
    else if (bus.cfg_ci > CI_MAX_C) ci_eff = CI_MAX_C;
    else                           ci_eff = bus.cfg_ci;
  end

  // Next-state and counter update for the layer walk.
  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    r_d     = r_q;
    g_d     = g_q;
    gm1_d   = gm1_q;
    ci_d    = ci_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_conv) begin
          ci_d    = ci_eff;
          gm1_d   = bus.cfg_co;
          g_d     = '0;
          k_d     = '0;
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (bus.rd_w_ack) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            r_d     = '0;
            j_d     = '0;
            state_d = S_LOAD_I;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_LOAD_I: begin
        if (bus.rd_i_ack) begin
          if (j_q == K_LAST) begin
            j_d     = '0;
            state_d = S_CLR;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (cnt_q == ci_q - CIW'(1)) state_d = S_DRAIN;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      S_DRAIN: begin
        if (bus.wr_o_ack) begin
          if (r_q < R_LAST) begin
            r_d     = r_q + 1'b1;
            j_d     = J_FIRST_NEXT;
            state_d = S_LOAD_I;
          end else if (g_q != gm1_q) begin
            g_d     = g_q + 1'b1;
            k_d     = '0;
            state_d = S_LOAD_W;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        g_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state is cleared on reset, including latched config, so the
    // sequencer never resumes from a stale layer after rst_n.
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      j_q     <= '0;
      r_q     <= '0;
      g_q     <= '0;
      gm1_q   <= '0;
      ci_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      r_q     <= r_d;
      g_q     <= g_d;
      gm1_q   <= gm1_d;
      ci_q    <= ci_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.end_conv  = (state_q == S_DONE);
  assign bus.rd_w_req  = (state_q == S_LOAD_W);
  assign bus.rd_i_req  = (state_q == S_LOAD_I);
  assign bus.pe_clr    = (state_q == S_CLR);
  assign bus.pe_en     = (state_q == S_COMPUTE);
  assign bus.wr_o_req  = (state_q == S_DRAIN);
  assign bus.w_row_idx = (state_q == S_LOAD_W) ? k_q : '0;
  assign bus.i_row_idx = (state_q == S_LOAD_I) ? r_q + HW'(j_q) : '0;
  assign bus.o_row_idx = (state_q == S_DRAIN) ? r_q : '0;
  assign bus.co_idx    = g_q;
endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Self-checking bench for conv_tile_sequencer (FMAP_H=64, K=4). A table of
// layer configurations is run end to end while a monitor tracks every
// handshake against an expected row/group walk; hand-written sequences then
// cover reset during COMPUTE and restart.
module tb_conv_tile_sequencer;
  localparam int FMAP_H = 64;
  localparam int K      = 4;
  localparam int ROWS   = FMAP_H - K + 1;
`ifdef ROW_REUSE_EN
  localparam int I_PER_GROUP = K + (ROWS - 1);
  localparam bit REUSE       = 1'b1;
`else
  localparam int I_PER_GROUP = K * ROWS;
  localparam bit REUSE       = 1'b0;
`endif

  typedef struct {
    logic [8:0] ci;
    logic [1:0] co;
    bit         bp;          // random ack delays on all ports
    bit         poke;        // extra start_conv pulse while busy
    int         exp_ci;      // expected accumulate cycles per row
    int         exp_groups;
    int         exp_writes;
    int         exp_pe;      // total pe_en cycles
  } vec_t;

  logic clk;
  logic rst_n;
  conv_tile_if #(.FMAP_H(FMAP_H), .K(K)) bus ();

  conv_tile_sequencer #(.FMAP_H(FMAP_H), .K(K), .CI_MAX(256), .CI_DEF(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.busy, bus.end_conv, bus.rd_w_req, bus.rd_i_req, bus.pe_clr,
                 bus.pe_en, bus.wr_o_req, bus.w_row_idx, bus.i_row_idx,
                 bus.o_row_idx, bus.co_idx});
  endfunction

  // ---------------- ack drivers ----------------
  bit bp_mode = 1'b0;
  int w_dly, i_dly, o_dly;

  function automatic logic next_ack(input logic req, input logic ack, inout int dly);
    logic a;
    a = ack;
    if (ack) begin
      a   = 1'b0;
      dly = int'($urandom_range(5, 0));
    end else if (req) begin
      if (dly == 0) a = 1'b1;
      else          dly--;
    end else begin
      dly = int'($urandom_range(5, 0));
    end
    return a;
  endfunction

  initial begin
    w_dly = 0; i_dly = 0; o_dly = 0;
    bus.rd_w_ack = 1'b0;
    bus.rd_i_ack = 1'b0;
    bus.wr_o_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!bp_mode) begin
        bus.rd_w_ack = 1'b1;
        bus.rd_i_ack = 1'b1;
        bus.wr_o_ack = 1'b1;
      end else begin
        bus.rd_w_ack = next_ack(bus.rd_w_req, bus.rd_w_ack, w_dly);
        bus.rd_i_ack = next_ack(bus.rd_i_req, bus.rd_i_ack, i_dly);
        bus.wr_o_ack = next_ack(bus.wr_o_req, bus.wr_o_ack, o_dly);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int w_acks, i_acks, writes, pe_total, run, run_min, run_max;
  int loadw_entries, end_cnt, writes_at_end;
  int seq_errs, stab_errs, excl_errs, clr_errs;
  int exp_k, cur_r, cur_j, cur_g;
  logic p_wreq, p_wack, p_ireq, p_iack, p_oreq, p_oack, p_clr, p_en, p_end;
  int p_widx, p_iidx, p_oidx;

  task automatic mon_clear();
    w_acks = 0; i_acks = 0; writes = 0; pe_total = 0; run = 0;
    run_min = 1 << 30; run_max = 0;
    loadw_entries = 0; end_cnt = 0; writes_at_end = -1;
    seq_errs = 0; stab_errs = 0; excl_errs = 0; clr_errs = 0;
    exp_k = 0; cur_r = 0; cur_j = 0; cur_g = 0;
    p_wreq = 0; p_wack = 0; p_ireq = 0; p_iack = 0; p_oreq = 0; p_oack = 0;
    p_clr = 0; p_en = 0; p_end = 0; p_widx = 0; p_iidx = 0; p_oidx = 0;
  endtask

  initial begin
    mon_clear();
    forever begin
      @(negedge clk);
      if (bus.end_conv) begin
        end_cnt++;
        writes_at_end = writes;
        if (p_end) seq_errs++;
      end
      if (rst_n) begin
        if (bus.pe_en && bus.pe_clr) excl_errs++;
        if ((bus.pe_en || bus.pe_clr) && (bus.rd_w_req || bus.rd_i_req || bus.wr_o_req))
          excl_errs++;
        if (bus.pe_clr && p_clr) clr_errs++;
        if (p_clr && !bus.pe_en) clr_errs++;
        if (bus.pe_en && !p_en && !p_clr) clr_errs++;
        if (bus.pe_en) begin
          pe_total++;
          run++;
        end else if (p_en) begin
          if (run < run_min) run_min = run;
          if (run > run_max) run_max = run;
          run = 0;
        end
        // held requests must keep their index until accepted
        if (p_wreq && !p_wack && (!bus.rd_w_req || int'(bus.w_row_idx) != p_widx)) stab_errs++;
        if (p_ireq && !p_iack && (!bus.rd_i_req || int'(bus.i_row_idx) != p_iidx)) stab_errs++;
        if (p_oreq && !p_oack && (!bus.wr_o_req || int'(bus.o_row_idx) != p_oidx)) stab_errs++;
        if (bus.rd_w_req && !p_wreq) loadw_entries++;
        if (bus.rd_w_req && bus.rd_w_ack) begin
          w_acks++;
          if (int'(bus.w_row_idx) != exp_k || int'(bus.co_idx) != cur_g) seq_errs++;
          exp_k++;
          if (exp_k == K) begin
            exp_k = 0;
            cur_r = 0;
            cur_j = 0;
          end
        end
        if (bus.rd_i_req && bus.rd_i_ack) begin
          i_acks++;
          if (int'(bus.i_row_idx) != cur_r + cur_j || int'(bus.co_idx) != cur_g) seq_errs++;
          cur_j++;
        end
        if (bus.wr_o_req && bus.wr_o_ack) begin
          writes++;
          if (int'(bus.o_row_idx) != cur_r || cur_j != K || int'(bus.co_idx) != cur_g)
            seq_errs++;
          cur_r++;
          cur_j = REUSE ? K - 1 : 0;
          if (cur_r == ROWS) begin
            cur_r = 0;
            cur_g++;
          end
        end
      end
      p_wreq = bus.rd_w_req; p_wack = bus.rd_w_ack; p_widx = int'(bus.w_row_idx);
      p_ireq = bus.rd_i_req; p_iack = bus.rd_i_ack; p_iidx = int'(bus.i_row_idx);
      p_oreq = bus.wr_o_req; p_oack = bus.wr_o_ack; p_oidx = int'(bus.o_row_idx);
      p_clr  = bus.pe_clr;   p_en   = bus.pe_en;    p_end  = bus.end_conv;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_layer(input logic [8:0] ci, input logic [1:0] co);
    bus.cfg_ci     = ci;
    bus.cfg_co     = co;
    bus.start_conv = 1'b1;
    @(posedge clk);
    #1;
    bus.start_conv = 1'b0;
    bus.cfg_ci     = ~ci;   // config changes while busy must be ignored
    bus.cfg_co     = ~co;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int cyc;
    mon_clear();
    bp_mode = v.bp;
    start_layer(v.ci, v.co);
    check({tag, "_busy_after_start"}, int'(bus.busy), 1);
    cyc = 0;
    while (end_cnt == 0 && cyc < 40000) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start_conv = (v.poke && cyc == 100);
    end
    bus.start_conv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_end_conv_count"}, end_cnt, 1);
    check({tag, "_w_acks"}, w_acks, K * v.exp_groups);
    check({tag, "_i_acks"}, i_acks, I_PER_GROUP * v.exp_groups);
    check({tag, "_writes"}, writes, v.exp_writes);
    check({tag, "_writes_at_end"}, writes_at_end, v.exp_writes);
    check({tag, "_pe_total"}, pe_total, v.exp_pe);
    check({tag, "_pe_run_min"}, run_min, v.exp_ci);
    check({tag, "_pe_run_max"}, run_max, v.exp_ci);
    check({tag, "_loadw_entries"}, loadw_entries, v.exp_groups);
    check({tag, "_seq_errs"}, seq_errs, 0);
    check({tag, "_stab_errs"}, stab_errs, 0);
    check({tag, "_excl_errs"}, excl_errs, 0);
    check({tag, "_clr_errs"}, clr_errs, 0);
    check({tag, "_idle_after_done"}, outs(), 0);
    if (end_cnt == 0) begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
    end
    bp_mode = 1'b0;
  endtask

  // ---------------- main test ----------------
  vec_t vecs[7];

  initial begin
    vec_t fresh;
    int   end_before;
    bit   found;

    //            ci      co    bp    poke  exp_ci grp writes pe
    vecs[0] = '{9'd32,  2'd0, 1'b0, 1'b0, 32,  1,  61,  1952};   // basic
    vecs[1] = '{9'd0,   2'd0, 1'b0, 1'b0, 32,  1,  61,  1952};   // default ci
    vecs[2] = '{9'd300, 2'd0, 1'b0, 1'b0, 256, 1,  61,  15616};  // clamp
    vecs[3] = '{9'd1,   2'd3, 1'b0, 1'b0, 1,   4,  244, 244};    // four groups
    vecs[4] = '{9'd3,   2'd1, 1'b1, 1'b0, 3,   2,  122, 366};    // backpressure
    vecs[5] = '{9'd2,   2'd2, 1'b1, 1'b0, 2,   3,  183, 366};    // backpressure
    vecs[6] = '{9'd2,   2'd0, 1'b0, 1'b1, 2,   1,  61,  122};    // start while busy

    rst_n          = 1'b0;
    bus.start_conv = 1'b0;
    bus.cfg_ci     = '0;
    bus.cfg_co     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_zero", outs(), 0);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", outs(), 0);

    for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset during COMPUTE of output row 10.
    mon_clear();
    bp_mode = 1'b0;
    start_layer(9'd4, 2'd0);
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(posedge clk);
      #1;
      if (cur_r == 10 && bus.pe_en) found = 1'b1;
    end
    check("rst_reached_row10", int'(found), 1);
    @(negedge clk);
    #2;
    check("rst_pe_en_before", int'(bus.pe_en), 1);
    end_before = end_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_outputs_zero_async", outs(), 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_end_conv", end_cnt - end_before, 0);
    check("rst_idle_after", outs(), 0);

    // Fresh start after reset completes normally.
    fresh = '{9'd5, 2'd0, 1'b0, 1'b0, 5, 1, 61, 305};
    run_vec("restart", fresh);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
